// File: rtl/nco_phase_gen.sv
// nco_phase_gen: phase accumulator NCO driving a sin/cos lookup read address
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   fcw_data_i      new frequency control word, offered with fcw_valid_i
//   fcw_valid_i     fcw_data_i is valid
//   fcw_ready_o     block can accept a new FCW
//   phase_offset_i  phase offset added to the address, sampled on each tick
//   sync_i          request to zero the accumulator on the next tick
//   r_addr_o        registered lookup read address
//   addr_valid_o    r_addr_o updated this cycle
//   data_valid_o    lookup outputs correspond to the last address
//   wrap_o          accumulator overflowed on the last tick
module nco_phase_gen #(
  parameter int ACC_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DIV = 1,
  parameter logic [ACC_WIDTH-1:0] FCW_DEFAULT = 32'h0010_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACC_WIDTH-1:0]  fcw_data_i,
  input  logic                  fcw_valid_i,
  output logic                  fcw_ready_o,
  input  logic [ADDR_WIDTH-1:0] phase_offset_i,
  input  logic                  sync_i,
  output logic [ADDR_WIDTH-1:0] r_addr_o,
  output logic                  addr_valid_o,
  output logic                  data_valid_o,
  output logic                  wrap_o
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic {IDLE, PEND} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, fcw_active_q, fcw_active_d, fcw_pend_q, fcw_pend_d, step, sum;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic sync_q, sync_d, sync_now, tick, accept, carry, wrap_d;
  logic fcw_ready_q, addr_valid_q, data_valid_q, wrap_q;
  assign tick = cnt_q == CW'(DIV - 1);
  // fcw_ready_q mirrors the IDLE state once out of reset
  assign accept = fcw_valid_i & fcw_ready_q;
  always_comb begin
    step = state_q == PEND ? fcw_pend_q : fcw_active_q;
    {carry, sum} = {1'b0, acc_q} + {1'b0, step};
    // a sync seen between ticks is held until the next tick services it
    sync_now = sync_i | sync_q;
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    sync_d = tick ? 1'b0 : sync_now;
    acc_d = !tick ? acc_q : sync_now ? '0 : sum;
    wrap_d = tick & ~sync_now & carry;
    r_addr_d = tick ? acc_d[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_offset_i : r_addr_q;
    fcw_pend_d = accept ? fcw_data_i : fcw_pend_q;
    fcw_active_d = (state_q == PEND && tick) ? fcw_pend_q : fcw_active_q;
    state_d = state_q == IDLE ? (accept ? PEND : IDLE) : (tick ? IDLE : PEND);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      fcw_active_q <= FCW_DEFAULT;
      fcw_pend_q <= '0;
      sync_q <= 1'b0;
      r_addr_q <= '0;
      fcw_ready_q <= 1'b0;
      addr_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      fcw_active_q <= fcw_active_d;
      fcw_pend_q <= fcw_pend_d;
      sync_q <= sync_d;
      r_addr_q <= r_addr_d;
      fcw_ready_q <= state_d == IDLE;
      addr_valid_q <= tick;
      data_valid_q <= addr_valid_q;
      wrap_q <= wrap_d;
    end
  end
  assign fcw_ready_o = fcw_ready_q;
  assign r_addr_o = r_addr_q;
  assign addr_valid_o = addr_valid_q;
  assign data_valid_o = data_valid_q;
  assign wrap_o = wrap_q;
endmodule

// File: tb/tb_nco_phase_gen.sv
// tb_nco_phase_gen: directed checks of nco_phase_gen at DIV=1 and DIV=4
module tb_nco_phase_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic a_rst_n, a_fcw_valid, a_sync, a_ready, a_av, a_dv, a_wrap;
  logic [31:0] a_fcw_data;
  logic [11:0] a_off, a_addr;
  logic b_rst_n, b_fcw_valid, b_sync, b_ready, b_av, b_dv, b_wrap;
  logic [31:0] b_fcw_data;
  logic [11:0] b_off, b_addr;
  nco_phase_gen #(.DIV(1)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .fcw_data_i(a_fcw_data), .fcw_valid_i(a_fcw_valid),
    .fcw_ready_o(a_ready), .phase_offset_i(a_off), .sync_i(a_sync), .r_addr_o(a_addr),
    .addr_valid_o(a_av), .data_valid_o(a_dv), .wrap_o(a_wrap)
  );
  nco_phase_gen #(.DIV(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .fcw_data_i(b_fcw_data), .fcw_valid_i(b_fcw_valid),
    .fcw_ready_o(b_ready), .phase_offset_i(b_off), .sync_i(b_sync), .r_addr_o(b_addr),
    .addr_valid_o(b_av), .data_valid_o(b_dv), .wrap_o(b_wrap)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_fcw_data = $urandom;
      a_fcw_valid = 1'($urandom);
      a_sync = 1'($urandom);
      a_off = 12'($urandom);
      b_fcw_data = $urandom;
      b_fcw_valid = 1'($urandom);
      b_sync = 1'($urandom);
      b_off = 12'($urandom);
      cyc(1);
      chk("rst_a_addr", 32'(a_addr), 0);
      chk("rst_a_av", 32'(a_av), 0);
      chk("rst_a_dv", 32'(a_dv), 0);
      chk("rst_a_wrap", 32'(a_wrap), 0);
      chk("rst_a_ready", 32'(a_ready), 0);
      chk("rst_b_addr", 32'(b_addr), 0);
      chk("rst_b_av", 32'(b_av), 0);
      chk("rst_b_ready", 32'(b_ready), 0);
    end
    a_fcw_valid = 1'b0;
    a_sync = 1'b0;
    a_off = '0;
    a_fcw_data = '0;
    a_rst_n = 1'b1;
    b_fcw_valid = 1'b0;
    b_sync = 1'b0;
    b_off = '0;
    b_fcw_data = '0;
    for (int k = 1; k <= 4097; k++) begin
      cyc(1);
      if (k == 1) chk("a_ready_after_rst", 32'(a_ready), 1);
      chk("a_ramp_addr", 32'(a_addr), 32'(k % 4096));
      chk("a_ramp_av", 32'(a_av), 1);
      chk("a_ramp_dv", 32'(a_dv), 32'(k >= 2));
      chk("a_ramp_wrap", 32'(a_wrap), 32'(k == 4096));
    end
    cyc(1);
    b_rst_n = 1'b1;
    cyc(1);
    chk("b_ready_c1", 32'(b_ready), 1);
    chk("b_av_c1", 32'(b_av), 0);
    cyc(3);
    chk("b_addr_c4", 32'(b_addr), 1);
    chk("b_av_c4", 32'(b_av), 1);
    cyc(1);
    chk("b_av_c5", 32'(b_av), 0);
    chk("b_dv_c5", 32'(b_dv), 1);
    chk("b_ready_c5", 32'(b_ready), 1);
    b_fcw_valid = 1'b1;
    b_fcw_data = 32'h0020_0000;
    cyc(1);
    chk("hs_ready_c6", 32'(b_ready), 0);
    cyc(1);
    chk("hs_ready_c7", 32'(b_ready), 0);
    chk("hs_addr_hold_c7", 32'(b_addr), 1);
    cyc(1);
    b_fcw_valid = 1'b0;
    chk("hs_ready_c8", 32'(b_ready), 1);
    chk("hs_addr_c8", 32'(b_addr), 3);
    chk("hs_av_c8", 32'(b_av), 1);
    cyc(4);
    chk("hs_addr_c12", 32'(b_addr), 5);
    chk("hs_ready_c12", 32'(b_ready), 1);
    b_rst_n = 1'b0;
    cyc(1);
    b_rst_n = 1'b1;
    b_off = 12'd16;
    cyc(4);
    chk("sy_addr_c4", 32'(b_addr), 17);
    cyc(4);
    chk("sy_addr_c8", 32'(b_addr), 18);
    cyc(1);
    b_sync = 1'b1;
    cyc(1);
    b_sync = 1'b0;
    chk("sy_addr_hold_c10", 32'(b_addr), 18);
    cyc(2);
    chk("sy_addr_c12", 32'(b_addr), 16);
    chk("sy_wrap_c12", 32'(b_wrap), 0);
    chk("sy_av_c12", 32'(b_av), 1);
    cyc(4);
    chk("sy_addr_c16", 32'(b_addr), 17);
    cyc(4);
    chk("sy_addr_c20", 32'(b_addr), 18);
    cyc(1);
    b_fcw_valid = 1'b1;
    b_fcw_data = 32'h0030_0000;
    cyc(1);
    b_fcw_valid = 1'b0;
    chk("sim_ready_c22", 32'(b_ready), 0);
    cyc(1);
    b_sync = 1'b1;
    cyc(1);
    b_sync = 1'b0;
    chk("sim_addr_c24", 32'(b_addr), 16);
    chk("sim_ready_c24", 32'(b_ready), 1);
    cyc(4);
    chk("sim_addr_c28", 32'(b_addr), 19);
    cyc(4);
    chk("sim_addr_c32", 32'(b_addr), 22);
    cyc(1);
    b_fcw_valid = 1'b1;
    b_fcw_data = 32'h0050_0000;
    cyc(1);
    b_fcw_valid = 1'b0;
    chk("mr_ready_pend", 32'(b_ready), 0);
    b_sync = 1'b1;
    cyc(1);
    b_sync = 1'b0;
    b_rst_n = 1'b0;
    cyc(1);
    chk("mr_ready_rst", 32'(b_ready), 0);
    chk("mr_av_rst", 32'(b_av), 0);
    chk("mr_dv_rst", 32'(b_dv), 0);
    chk("mr_addr_rst", 32'(b_addr), 0);
    b_rst_n = 1'b1;
    cyc(1);
    chk("mr_ready_c1", 32'(b_ready), 1);
    cyc(3);
    chk("mr_addr_c4", 32'(b_addr), 17);
    cyc(4);
    chk("mr_addr_c8", 32'(b_addr), 18);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nco_phase_gen.md
# nco_phase_gen

Numerically controlled phase generator for the analog PLL datapath. Keeps a wide phase accumulator stepped by a frequency control word (FCW), and drives the read address of the sin/cos lookup memory directly downstream, which has one cycle of read latency. The loop filter updates the FCW through a valid/ready handshake. A sync input realigns phase, and a data-valid strobe is aligned with the lookup memory's registered outputs.

## Interface
- ACC_WIDTH, 32: phase accumulator width in bits.
- ADDR_WIDTH, 12: lookup address width; the address is the top ADDR_WIDTH accumulator bits plus the offset.
- DIV, 1: clock cycles per sample tick, must be at least 1.
- FCW_DEFAULT, 32'h0010_0000: FCW loaded at reset.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- fcw_data  in  ACC_WIDTH  new frequency control word.
- fcw_valid  in  1  fcw_data is offered.
- fcw_ready  out  1  block can accept an FCW.
- phase_offset  in  ADDR_WIDTH  static phase offset added to the address, sampled on each tick.
- sync  in  1  single-cycle request to zero the accumulator.
- r_addr  out  ADDR_WIDTH  registered read address to the sin/cos lookup memory.
- addr_valid  out  1  one-cycle pulse: r_addr was updated this cycle.
- data_valid  out  1  one-cycle pulse: lookup memory outputs correspond to the last address.
- wrap  out  1  one-cycle pulse: accumulator overflowed on the last tick.

## Operation
- **Reset values** (while rst_n=0 at an edge):
  - acc=0, fcw_active=FCW_DEFAULT, pending=0, tick counter=0.
  - r_addr=0, addr_valid=0, data_valid=0, wrap=0.
  - fcw_ready=0 during reset, 1 from the first cycle after reset.
- **Tick generator**: counter counts 0..DIV-1 and wraps. tick=1 in the cycle the counter equals DIV-1. With DIV=1, tick=1 every cycle.
- **FCW state machine**, two states:
  - IDLE: fcw_ready=1. On fcw_valid&fcw_ready, load fcw_pend and go to PEND.
  - PEND: fcw_ready=0. On a tick, copy fcw_pend to fcw_active and return to IDLE.
  - fcw_valid is ignored while in PEND.
- **Step on tick** (in order of precedence):
  - Step word: if PEND at the tick, the tick uses fcw_pend; otherwise it uses fcw_active.
  - Sync: if sync is asserted, or was latched since the last tick, acc_next=0 and wrap=0.
  - Otherwise: acc_next = acc + step, modulo 2^ACC_WIDTH. wrap=carry out of the MSB.
  - sync asserted in a non-tick cycle is latched and serviced on the next tick. Multiple syncs collapse into one.
- **Address**: r_addr <= acc_next[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_offset, modulo 2^ADDR_WIDTH. r_addr holds its value between ticks.
- **Strobes**:
  - addr_valid=1 for the cycle after a tick.
  - data_valid is addr_valid delayed by one cycle.
  - wrap is registered alongside addr_valid.
- **Same-tick events**: sync and FCW apply on the same tick. acc_next=0 and fcw_active is updated; the new word takes effect on the following tick.
- **Reset mid-operation**: any pending FCW and any latched sync are discarded. In-flight addr_valid/data_valid are cleared.

## Timing
- Tick in cycle T: acc, r_addr, addr_valid and wrap are visible in T+1.
- The lookup memory samples r_addr at the end of T+1. Its data and data_valid are visible in T+2.
- Total latency from tick to usable sin/cos is 2 cycles.
- FCW accepted at edge N:
  - fcw_ready=0 from N+1.
  - Applied on the first tick in cycle ≥ N+1.
  - fcw_ready returns to 1 the cycle after that tick.
  - Minimum FCW turnaround is 2 cycles when DIV=1.
- addr_valid pulses have period DIV and are exactly one cycle wide. When DIV=1, addr_valid is held continuously high.
- phase_offset changes take effect at the next tick only.

## Test plan
- **Reset**: hold rst_n=0 for 3 cycles with random inputs. Require r_addr=0, strobes=0 and fcw_ready=0. After release, fcw_ready=1 and the first addr_valid arrives on cycle 1.
- **Ramp and wrap**: DIV=1, FCW=2^20, offset=0. Require r_addr = 1, 2, 3, … one per cycle, and data_valid to track addr_valid one cycle later. After 4096 ticks, require r_addr=0 with a single-cycle wrap pulse.
- **FCW handshake**: DIV=4, write FCW=2^21 with fcw_valid held for 3 cycles. Require exactly one acceptance and fcw_ready low until the tick. Address steps change from 1 to 2 starting at that tick.
- **Sync**: running with FCW=2^20, offset=16. Assert sync in a non-tick cycle (DIV=4). Require the next r_addr=16, then 17, 18, … with wrap=0 on the sync tick.
- **Simultaneous events**: assert sync on the same tick a pending FCW=3·2^20 is applied. Require r_addr=offset, then offset+3.
- **Reset mid-operation**: pull rst_n low while in PEND with sync latched. After release, require fcw_active=FCW_DEFAULT (step 1), no sync effect and fcw_ready=1.
